// File: rtl/wb_mem_port.sv
// wb_mem_port: fixed-priority Wishbone master port shared by NUM_CH requesters.
// Generates byte-lane selects, lane-shifts store data and extends sub-word loads.
// Misaligned or oversize accesses complete with an error and no bus cycle.
// Optional feature: define WB_MEM_PORT_TIMEOUT_EN to add a bus watchdog that ends
// a stalled cycle with an error after TIMEOUT_CYCLES cycles.
module wb_mem_port #(
  parameter int NUM_CH         = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [2*NUM_CH-1:0]      ch_size,
  input  logic [NUM_CH-1:0]        ch_unsigned,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic                     ch_err,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ADDR_W-1:0]        wb_adr_o,
  output logic [DATA_W-1:0]        wb_dat_o,
  output logic [DATA_W/8-1:0]      wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic [DATA_W-1:0]        wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 8 || (DATA_W != 32 && DATA_W != 64) ||
      ADDR_W < 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_mem_port: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;

  logic [GW-1:0]    gnt_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             we_q;
  logic [OFF_W-1:0] off_q;
  logic             timeout;

  logic              req_any;
  logic [GW-1:0]     gnt_idx;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [1:0]        g_size;
  logic              g_we;
  logic              g_uns;
  logic [OFF_W-1:0]  g_off;
  logic [31:0]       g_nb;
  logic [31:0]       g_offu;
  logic              g_misalign;
  logic              g_bad;
  logic [SEL_W-1:0]  g_sel;
  logic [DATA_W-1:0] g_wmask;
  logic [DATA_W-1:0] g_dat;

  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ld_ext;
  logic [31:0]       ld_bits;
  logic              ld_sign;

  // Fixed-priority arbiter: lowest asserted index wins
  always_comb begin
    req_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_req[i] && !req_any) begin
        req_any = 1'b1;
        gnt_idx = GW'(i);
      end
    end
  end

  // Route the winning channel's request fields
  always_comb begin
    g_addr  = ch_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    g_wdata = ch_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    g_size  = ch_size[int'(gnt_idx)*2 +: 2];
    g_we    = ch_we[gnt_idx];
    g_uns   = ch_unsigned[gnt_idx];
  end

  // Access legality, byte-lane selects and lane-shifted store data
  always_comb begin
    g_off  = g_addr[OFF_W-1:0];
    g_nb   = 32'd1 << g_size;
    g_offu = 32'(g_off);
    case (g_size)
      2'd0:    g_misalign = 1'b0;
      2'd1:    g_misalign = g_addr[0];
      2'd2:    g_misalign = |g_addr[1:0];
      default: g_misalign = |g_addr[2:0];
    endcase
    g_bad = g_misalign || (32'(g_size) > 32'(OFF_W));
    g_sel = '0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      g_sel[i] = (i >= g_offu) && (i < g_offu + g_nb);
    end
    g_wmask = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      g_wmask[i] = (i < 8 * g_nb);
    end
    g_dat = (g_wdata & g_wmask) << {g_off, 3'b000};
  end

  // Right-justify the addressed bytes of the read data and extend them
  always_comb begin
    rd_shift = wb_dat_i >> {off_q, 3'b000};
    ld_bits  = 32'd8 << size_q;
    case (size_q)
      2'd0:    ld_sign = rd_shift[7];
      2'd1:    ld_sign = rd_shift[15];
      2'd2:    ld_sign = rd_shift[31];
      default: ld_sign = rd_shift[DATA_W-1];
    endcase
    ld_ext = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      ld_ext[i] = (i < ld_bits) ? rd_shift[i] : (!uns_q && ld_sign);
    end
  end

`ifdef WB_MEM_PORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Watchdog: held at zero outside BUS, so every bus cycle starts counting from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tmo_cnt <= '0;
    else if (state != BUS)  tmo_cnt <= '0;
    else                    tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign timeout = (state == BUS) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Main FSM with registered bus and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      off_q    <= '0;
      ch_ack   <= '0;
      ch_err   <= 1'b0;
      ch_rdata <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ch_ack <= '0;
          ch_err <= 1'b0;
          if (req_any) begin
            gnt_q  <= gnt_idx;
            size_q <= g_size;
            uns_q  <= g_uns;
            we_q   <= g_we;
            off_q  <= g_off;
            if (g_bad) begin
              state    <= RESP;
              ch_ack   <= NUM_CH'(1) << gnt_idx;
              ch_err   <= 1'b1;
              ch_rdata <= '0;
            end else begin
              state    <= BUS;
              wb_adr_o <= g_addr & ~ADDR_W'(SEL_W - 1);
              wb_dat_o <= g_dat;
              wb_sel_o <= g_sel;
              wb_we_o  <= g_we;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
            end
          end
        end
        BUS: begin
          if (wb_ack_i || wb_err_i || timeout) begin
            state    <= RESP;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            ch_ack   <= NUM_CH'(1) << gnt_q;
            // Reaching here with neither ack nor err means the watchdog fired
            ch_err   <= wb_err_i || !wb_ack_i;
            ch_rdata <= we_q ? '0 : ld_ext;
          end
        end
        RESP: begin
          state  <= IDLE;
          ch_ack <= '0;
          ch_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_port.sv
// Directed self-checking bench for wb_mem_port (2 channels, 32-bit bus).
module tb_wb_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_req, ch_we, ch_unsigned, ch_ack;
  logic [3:0]  ch_size;
  logic [63:0] ch_addr, ch_wdata;
  logic        ch_err;
  logic [31:0] ch_rdata, wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

  int checks = 0;
  int errors = 0;

  wb_mem_port #(
    .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_req(ch_req), .ch_we(ch_we), .ch_size(ch_size), .ch_unsigned(ch_unsigned),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_ack(ch_ack), .ch_err(ch_err), .ch_rdata(ch_rdata),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  // Drive one request on channel ch and act as the slave: respond on the
  // (waits+1)-th strobe cycle with the given ack/err/data. lat is the number of
  // negedges from the request edge to the ch_ack pulse (-1 if it never pulses).
  task automatic run_txn(input int ch, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rdat, input logic berr,
                         input logic back,
                         output int lat, output int stb_cycles,
                         output logic [31:0] adr_s, output logic [31:0] dat_s,
                         output logic [3:0] sel_s, output logic we_s,
                         output logic [1:0] ack_s, output logic err_s,
                         output logic [31:0] rd_s);
    lat = -1; stb_cycles = 0;
    adr_s = '0; dat_s = '0; sel_s = '0; we_s = 1'b0; ack_s = '0; err_s = 1'b0; rd_s = '0;
    @(negedge clk);
    ch_we[ch]            = we;
    ch_size[2*ch +: 2]   = size;
    ch_unsigned[ch]      = uns;
    ch_addr[32*ch +: 32] = addr;
    ch_wdata[32*ch +: 32] = wdata;
    ch_req[ch]           = 1'b1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (ch_ack != 2'b00) begin
        lat = k; ack_s = ch_ack; err_s = ch_err; rd_s = ch_rdata;
        ch_req[ch] = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      end else if (wb_cyc_o && wb_stb_o) begin
        stb_cycles++;
        if (stb_cycles == 1) begin
          adr_s = wb_adr_o; dat_s = wb_dat_o; sel_s = wb_sel_o; we_s = wb_we_o;
        end
        if (stb_cycles == waits + 1) begin
          wb_ack_i = back; wb_err_i = berr; wb_dat_i = rdat;
        end
      end
    end
    ch_req[ch] = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch_req = '0; ch_we = '0; ch_unsigned = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin errors++;
      $display("FAIL reset_bus: got %h expected 0", {wb_adr_o, wb_dat_o, wb_sel_o}); end
    checks++; if ({ch_ack, ch_err, ch_rdata} !== 35'h0) begin errors++;
      $display("FAIL reset_resp: got %h expected 0", {ch_ack, ch_err, ch_rdata}); end
    rst = 1'b0;
  endtask

  task automatic test_word_load();
    int lat, sc; logic [31:0] adr, dat, rd; logic [3:0] sel; logic we, err; logic [1:0] ack;
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wl_latency: got %0d expected 4", lat); end
    checks++; if (sc !== 3) begin errors++; $display("FAIL wl_stb_cycles: got %0d expected 3", sc); end
    checks++; if (sel !== 4'hF) begin errors++; $display("FAIL wl_sel: got %h expected f", sel); end
    checks++; if (adr !== 32'h100) begin errors++; $display("FAIL wl_adr: got %h expected 00000100", adr); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL wl_we: got %b expected 0", we); end
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL wl_ack: got %b expected 01", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wl_err: got %b expected 0", err); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_rdata: got %h expected deadbeef", rd); end
    @(negedge clk);
    checks++; if (ch_ack !== 2'b00) begin errors++; $display("FAIL wl_ack_pulse: got %b expected 00", ch_ack); end
  endtask

  task automatic test_subword_load();
    int lat, sc; logic [31:0] adr, dat, rd; logic [3:0] sel; logic we, err; logic [1:0] ack;
    run_txn(0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80112233, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (sel !== 4'b1000) begin errors++; $display("FAIL lb_sel: got %b expected 1000", sel); end
    checks++; if (adr !== 32'h100) begin errors++; $display("FAIL lb_adr: got %h expected 00000100", adr); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lb_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h expected ffffff80", rd); end
    run_txn(0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80112233, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_unsigned: got %h expected 00000080", rd); end
    run_txn(0, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 1, 32'hA5A57F00, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (sel !== 4'b0010) begin errors++; $display("FAIL lb1_sel: got %b expected 0010", sel); end
    checks++; if (rd !== 32'h0000007F) begin errors++; $display("FAIL lb1_positive: got %h expected 0000007f", rd); end
    run_txn(0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, 32'h80011234, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (sel !== 4'b1100) begin errors++; $display("FAIL lh_sel: got %b expected 1100", sel); end
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_signed: got %h expected ffff8001", rd); end
  endtask

  task automatic test_store();
    int lat, sc; logic [31:0] adr, dat, rd; logic [3:0] sel; logic we, err; logic [1:0] ack;
    run_txn(0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 0, 32'hFFFFFFFF, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (adr !== 32'h200) begin errors++; $display("FAIL sh_adr: got %h expected 00000200", adr); end
    checks++; if (sel !== 4'b1100) begin errors++; $display("FAIL sh_sel: got %b expected 1100", sel); end
    checks++; if (dat !== 32'hBEEF0000) begin errors++; $display("FAIL sh_dat: got %h expected beef0000", dat); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b expected 1", we); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sh_rdata: got %h expected 00000000", rd); end
    run_txn(0, 1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFFFFAB, 0, 32'h0, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (sel !== 4'b0010) begin errors++; $display("FAIL sb_sel: got %b expected 0010", sel); end
    checks++; if (dat !== 32'h0000AB00) begin errors++; $display("FAIL sb_dat: got %h expected 0000ab00", dat); end
    run_txn(1, 1'b1, 2'd2, 1'b0, 32'h300, 32'h01234567, 0, 32'h0, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (ack !== 2'b10) begin errors++; $display("FAIL sw_ch1_ack: got %b expected 10", ack); end
    checks++; if ({sel, dat} !== {4'hF, 32'h01234567}) begin errors++;
      $display("FAIL sw_ch1_lanes: got %h expected f01234567", {sel, dat}); end
  endtask

  task automatic test_priority();
    int ack0_k, stb1_k, ack1_k; logic [31:0] first_adr, rd1;
    ack0_k = -1; stb1_k = -1; ack1_k = -1; first_adr = '0; rd1 = '0;
    @(negedge clk);
    ch_we = 2'b00; ch_unsigned = 2'b00; ch_size = 4'b1010;
    ch_addr = {32'h400, 32'h100};
    ch_req = 2'b11;
    for (int k = 1; k <= 30 && ack1_k < 0; k++) begin
      @(negedge clk);
      if (ch_ack != 2'b00) begin
        if (ch_ack == 2'b01 && ack0_k < 0) begin ack0_k = k; ch_req[0] = 1'b0; end
        else if (ch_ack == 2'b10) begin ack1_k = k; rd1 = ch_rdata; ch_req[1] = 1'b0; end
        wb_ack_i = 1'b0;
      end else if (wb_cyc_o && wb_stb_o) begin
        if (k == 1) first_adr = wb_adr_o;
        if (wb_adr_o == 32'h400 && stb1_k < 0) stb1_k = k;
        wb_ack_i = 1'b1;
        wb_dat_i = (wb_adr_o == 32'h400) ? 32'h12345678 : 32'hCAFEF00D;
      end
    end
    ch_req = 2'b00; wb_ack_i = 1'b0;
    checks++; if (first_adr !== 32'h100) begin errors++; $display("FAIL pri_first_adr: got %h expected 00000100", first_adr); end
    checks++; if (ack0_k !== 2) begin errors++; $display("FAIL pri_ack0_cycle: got %0d expected 2", ack0_k); end
    // RESP at 2, IDLE grants ch1 at 3, its strobe appears at 4
    checks++; if (stb1_k !== 4) begin errors++; $display("FAIL pri_stb1_cycle: got %0d expected 4", stb1_k); end
    checks++; if (ack1_k !== 5) begin errors++; $display("FAIL pri_ack1_cycle: got %0d expected 5", ack1_k); end
    checks++; if (rd1 !== 32'h12345678) begin errors++; $display("FAIL pri_rdata1: got %h expected 12345678", rd1); end
  endtask

  task automatic test_errors();
    int lat, sc; logic [31:0] adr, dat, rd; logic [3:0] sel; logic we, err; logic [1:0] ack;
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 32'h0, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency: got %0d expected 1", lat); end
    checks++; if (sc !== 0) begin errors++; $display("FAIL mis_no_cyc: got %0d expected 0", sc); end
    checks++; if ({ack, err} !== 3'b011) begin errors++; $display("FAIL mis_ack_err: got %b expected 011", {ack, err}); end
    run_txn(0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if ({lat == 1, sc == 0, err} !== 3'b111) begin errors++;
      $display("FAIL oversize: got lat %0d stb %0d err %b expected 1 0 1", lat, sc, err); end
    run_txn(1, 1'b1, 2'd1, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if ({ack, err, sc == 0} !== 4'b1011) begin errors++;
      $display("FAIL mis_half_ch1: got ack %b err %b stb %0d expected 10 1 0", ack, err, sc); end
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b1, 1'b0,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if ({lat == 2, err} !== 2'b11) begin errors++;
      $display("FAIL bus_err: got lat %0d err %b expected 2 1", lat, err); end
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 1, 32'h0, 1'b1, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_wins: got %b expected 1", err); end
  endtask

`ifdef WB_MEM_PORT_TIMEOUT_EN
  task automatic test_timeout();
    int lat, sc, late_acks; logic [31:0] adr, dat, rd; logic [3:0] sel; logic we, err; logic [1:0] ack;
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b0, 1'b0,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if (sc !== 8) begin errors++; $display("FAIL tmo_cyc_cycles: got %0d expected 8", sc); end
    checks++; if ({lat == 9, ack, err} !== 4'b1011) begin errors++;
      $display("FAIL tmo_resp: got lat %0d ack %b err %b expected 9 01 1", lat, ack, err); end
    late_acks = 0;
    wb_ack_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ch_ack != 2'b00 || wb_cyc_o) late_acks++;
    end
    wb_ack_i = 1'b0;
    checks++; if (late_acks !== 0) begin errors++; $display("FAIL tmo_late_ack: got %0d expected 0", late_acks); end
  endtask
`endif

  task automatic test_reset_mid_bus();
    int seen, acks, lat, sc; logic [31:0] adr, dat, rd; logic [3:0] sel; logic we, err; logic [1:0] ack;
    seen = 0; acks = 0;
    @(negedge clk);
    ch_we[0] = 1'b0; ch_size[1:0] = 2'd2; ch_addr[31:0] = 32'h100; ch_req[0] = 1'b1;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (wb_cyc_o) seen = 1;
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL rstb_cyc_seen: got %0d expected 1", seen); end
    @(negedge clk);
    rst = 1'b1; ch_req = 2'b00;
    #1;
    checks++; if ({wb_cyc_o, wb_stb_o, ch_ack} !== 4'b0000) begin errors++;
      $display("FAIL rstb_drop: got %b expected 0000", {wb_cyc_o, wb_stb_o, ch_ack}); end
    @(negedge clk);
    rst = 1'b0;
    wb_ack_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ch_ack != 2'b00) acks++;
    end
    wb_ack_i = 1'b0;
    checks++; if (acks !== 0) begin errors++; $display("FAIL rstb_no_ack: got %0d expected 0", acks); end
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h108, 32'h0, 0, 32'h55AA00FF, 1'b0, 1'b1,
            lat, sc, adr, dat, sel, we, ack, err, rd);
    checks++; if ({lat == 2, rd} !== {1'b1, 32'h55AA00FF}) begin errors++;
      $display("FAIL rstb_recover: got lat %0d rdata %h expected 2 55aa00ff", lat, rd); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_store();
    test_priority();
    test_errors();
`ifdef WB_MEM_PORT_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
